// File: rtl/serializer_pkg.sv
// Shared state encoding and sizing helper for the bit-stream serializer.
package serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Bit-counter width for a word of 'width' bits (never below 1).
   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder: the first bit is on x the cycle after accept, one bit per clock; load_ready is high only in IDLE,
// or with SERIALIZER_SKID_EN it is high while the one-entry holding register is empty, which makes back-to-back words gapless.
module bit_stream_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             frame_done
);

   localparam int                CNT_W    = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [WIDTH-1:0]   sreg, sreg_n, shifted;
   logic               last, acc;
`ifdef SERIALIZER_SKID_EN
   logic [WIDTH-1:0]   hold, hold_n;
   logic               hold_full, hold_full_n;
`endif

   assign busy       = (state == ST_SHIFT);
   assign x_valid    = busy;
   assign last       = busy && (cnt == LAST_CNT);
   assign frame_done = last;
   assign x          = busy && ((MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0]);
   assign shifted    = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

   // Reset blocks acceptance in the same cycle, so rst always wins over load_valid.
`ifdef SERIALIZER_SKID_EN
   assign load_ready = !hold_full && !rst;
`else
   assign load_ready = (state == ST_IDLE) && !rst;
`endif
   assign acc = load_valid && load_ready;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sreg_n  = sreg;
`ifdef SERIALIZER_SKID_EN
      hold_n      = hold;
      hold_full_n = hold_full;
`endif
      case (state)
         ST_IDLE: begin
            if (acc) begin
               state_n = ST_SHIFT;
               cnt_n   = '0;
               sreg_n  = load_data;
            end
         end
         ST_SHIFT: begin
            if (!last) begin
               cnt_n  = cnt + 1'b1;
               sreg_n = shifted;
`ifdef SERIALIZER_SKID_EN
               if (acc) begin
                  hold_n      = load_data;
                  hold_full_n = 1'b1;
               end
`endif
            end else begin
               cnt_n = '0;
`ifdef SERIALIZER_SKID_EN
               // Held word takes priority; a fresh word goes straight to the shifter only if nothing is held.
               if (hold_full) begin
                  sreg_n = hold;
                  if (acc) hold_n = load_data;
                  else     hold_full_n = 1'b0;
               end else if (acc) begin
                  sreg_n = load_data;
               end else begin
                  state_n = ST_IDLE;
                  sreg_n  = '0;
               end
`else
               state_n = ST_IDLE;
               sreg_n  = '0;
`endif
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         sreg  <= '0;
`ifdef SERIALIZER_SKID_EN
         hold      <= '0;
         hold_full <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         sreg  <= sreg_n;
`ifdef SERIALIZER_SKID_EN
         hold      <= hold_n;
         hold_full <= hold_full_n;
`endif
      end
   end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: MSB-first and LSB-first instances share stimulus and are checked against a bit-queue model.
module tb_bit_stream_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load_valid = 1'b0;
   logic [W-1:0] load_data = '0;

   logic rdy_m, x_m, xv_m, busy_m, fd_m;
   logic rdy_l, x_l, xv_l, busy_l, fd_l;

   int total = 0;
   int bad   = 0;

   // Expected future bit stream per instance; head is what the current cycle must show.
   bit q_msb[$];
   bit q_lsb[$];
   bit q_last[$];

   always #5 clk = ~clk;

   bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_m), .load_data(load_data),
      .x(x_m), .x_valid(xv_m), .busy(busy_m), .frame_done(fd_m)
   );

   bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_l), .load_data(load_data),
      .x(x_l), .x_valid(xv_l), .busy(busy_l), .frame_done(fd_l)
   );

   task automatic check(input string tag, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%b exp=%b", tag, $time, got, exp);
      end
   endtask

   // Base build takes a word only when nothing is queued; the skid build while at most the current word remains.
   function automatic bit exp_ready();
`ifdef SERIALIZER_SKID_EN
      return q_msb.size() <= W;
`else
      return q_msb.size() == 0;
`endif
   endfunction

   task automatic step(output bit acc);
      bit hv;
      bit er;
      @(negedge clk);
      hv = (q_msb.size() > 0);
      er = exp_ready();
      check("ready_msb", rdy_m, !rst && er);
      check("ready_lsb", rdy_l, !rst && er);
      check("xvalid_msb", xv_m, hv);
      check("xvalid_lsb", xv_l, hv);
      check("busy_msb", busy_m, hv);
      check("busy_lsb", busy_l, hv);
      check("x_msb", x_m, hv ? q_msb[0] : 1'b0);
      check("x_lsb", x_l, hv ? q_lsb[0] : 1'b0);
      check("fdone_msb", fd_m, hv ? q_last[0] : 1'b0);
      check("fdone_lsb", fd_l, hv ? q_last[0] : 1'b0);
      acc = load_valid && !rst && er;
      @(posedge clk);
      if (rst) begin
         q_msb.delete();
         q_lsb.delete();
         q_last.delete();
      end else begin
         if (hv) begin
            void'(q_msb.pop_front());
            void'(q_lsb.pop_front());
            void'(q_last.pop_front());
         end
         if (acc) begin
            for (int i = 0; i < W; i++) begin
               q_msb.push_back(load_data[W-1-i]);
               q_lsb.push_back(load_data[i]);
               q_last.push_back(i == W - 1);
            end
         end
      end
      #1;
   endtask

   task automatic step_n(input int n);
      bit a;
      repeat (n) step(a);
   endtask

   // Presents a word and waits (bounded) until it is taken; load_valid is left high.
   task automatic feed(input logic [W-1:0] d);
      bit acc;
      load_valid = 1'b1;
      load_data  = d;
      acc        = 1'b0;
      for (int i = 0; i < 40 && !acc; i++) step(acc);
      check("feed_accepted", acc, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      step_n(2);
      rst = 1'b0;

      feed(8'b0100_0111);
      load_valid = 1'b0;
      step_n(10);

      feed(8'hA5);
      load_valid = 1'b0;
      step_n(10);

      feed(8'hFF);
      feed(8'h00);
      load_valid = 1'b0;
      step_n(12);

      feed(8'hF0);
      feed(8'h0F);
      feed(8'hAA);
      load_valid = 1'b0;
      step_n(30);

      feed(8'hC3);
      load_valid = 1'b0;
      step_n(3);
      rst = 1'b1;
      step_n(1);
      rst = 1'b0;
      step_n(3);

      rst        = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'h3C;
      step_n(1);
      rst        = 1'b0;
      load_valid = 1'b0;
      step_n(2);

      feed(8'h11);
      load_valid = 1'b0;
      step_n(3);
      load_valid = 1'b1;
      load_data  = 8'h55;
      step_n(1);
      load_valid = 1'b0;
      step_n(20);

      repeat (3000) begin
         bit a;
         rst        = ($urandom_range(0, 99) == 0);
         load_valid = ($urandom_range(0, 2) != 0);
         load_data  = W'($urandom);
         step(a);
      end
      rst        = 1'b0;
      load_valid = 1'b0;
      step_n(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
Upstream feeder for the serial sequence-detector FSMs (machine_d family). Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on x, with x_valid framing. Produces the bit stream the detector samples each clock, so both directed and random stimulus can be driven as words instead of hand-timed bits.

Parameters:
WIDTH, 8, bits per word; must be at least 2.
MSB_FIRST, 1, 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
load_valid  input  1  load_data is valid this cycle
load_ready  output  1  block can accept a word this cycle
load_data  input  WIDTH  parallel word to serialize
x  output  1  serial bit stream; drives the detector's x input
x_valid  output  1  x carries a word bit this cycle
busy  output  1  a word is being shifted (state SHIFT)
frame_done  output  1  single-cycle pulse on the last bit of each word

Behaviour:
- Reset values: x=0, x_valid=0, busy=0, frame_done=0, load_ready=0 during the rst cycle, and load_ready=1 on the first cycle after rst deasserts. Bit counter=0, shift register=0.
- Reset mid-frame aborts the word immediately. No remaining bits are emitted, and the holding register (if present) is cleared.
- Accept event: load_valid && load_ready sampled at a rising edge. load_data is captured at that edge.
- FSM states:
  - IDLE: busy=0, x_valid=0, x=0 (idle bits are zero so the detector sees a defined 0). load_ready=1. On accept, go to SHIFT.
  - SHIFT: busy=1, x_valid=1, x = current bit. The bit counter runs 0..WIDTH-1. When the counter reaches WIDTH-1, frame_done=1 for that cycle. On the next edge, load the next word if one is available (see Optional Feature); otherwise go to IDLE.
- Latency: a word accepted at edge N drives its first bit in the cycle after edge N. The last bit appears in the cycle after edge N+WIDTH-1.
- Bit order: MSB_FIRST=1 emits load_data[WIDTH-1] down to load_data[0]; MSB_FIRST=0 emits the reverse order.
- Base build: load_ready=1 only in IDLE. Back-to-back words are therefore separated by exactly one IDLE cycle with x=0, x_valid=0.
- load_valid while not ready is ignored. No capture occurs and no error is raised; the data is simply not taken.
- Counter width is $clog2(WIDTH). The counter wraps to 0 on every new load and never free-runs in IDLE.
- Simultaneous rst and load_valid: rst wins and nothing is captured.

Optional Feature:
Macro SERIALIZER_SKID_EN.
- Defined: adds a one-entry holding register plus a hold_full flag, and load_ready = !hold_full, including during SHIFT.
  - On the last-bit cycle, if hold_full, the held word moves into the shift register at the next edge. The stream stays gapless (x_valid stays 1) and hold_full clears.
  - An accept during the last-bit cycle while hold_full=0 also goes straight into the shift register, again gapless.
  - An accept and a holding-register drain on the same edge leave hold_full=1.
- Undefined: no holding register; base behaviour applies (one-cycle gap between words).

Decomposition:
- Package serializer_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - a counter-width helper, CNT_W = $clog2(WIDTH).
- No sub-module is required. The bit counter stays inline; it is too small to justify a separate module.
- Benches instantiate bit_stream_serializer directly feeding machine_d (x to x, shared clk and rst).

Test Plan:
- Reset then single word: rst=1 for 2 cycles, then load 8'b0100_0111 with MSB_FIRST=1 -> x = 0,1,0,0,0,1,1,1 on cycles 1-8 after accept; x_valid=1 for those 8 cycles; frame_done=1 only on cycle 8.
- LSB order: MSB_FIRST=0, load 8'hA5 -> x = 1,0,1,0,0,1,0,1.
- Back-to-back, base build: load_valid held high with 8'hFF then 8'h00 -> one cycle of x=0, x_valid=0 between the words; load_ready=1 only in IDLE cycles.
- Back-to-back with SERIALIZER_SKID_EN: 8'hF0, 8'h0F, 8'hAA queued -> 24 consecutive x_valid=1 cycles with no gap; load_ready drops while hold_full=1.
- Reset mid-frame: assert rst after the 3rd bit of 8'hC3 -> next cycle x=0, x_valid=0, busy=0; load_ready=1 after rst deasserts; no stale bits appear.
- Ignored load: pulse load_valid during SHIFT (base build) with 8'h55 -> word not captured; only the current word is emitted.
